melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Parametrised, tempo-driven note sequencer for the speaker path. It holds a run-time-loadable table of per-channel note dividers, advances a beat index at a programmable tempo, and drives the divider buses straight into the existing tone generators. It replaces fixed two-digit beat-to-divider lookups with play, pause, stop and loop control, and emits the beat index as BCD digits for the seven-segment display.

## Interface
- `CH`, 2: number of audio channels; `CH=2` is {left, right}.
- `DIV_W`, 22: divider width per channel; value 0 = rest (silence).
- `NUM_BEATS`, 32: table depth; legal range 2..100.
- `TICK_DIV`, 25_000_000: clock cycles per beat; must be ≥ 2.
- `IDX_W`, `$clog2(NUM_BEATS)`: beat index width (derived).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: latch `seq_len` and play from beat 0.
- `stop`  in  1  one-cycle pulse: return to IDLE.
- `pause`  in  1  level: while high in PLAY, hold position and mute.
- `loop_en`  in  1  level: wrap to beat 0 after the last beat instead of finishing.
- `seq_len`  in  IDX_W+1  active length in beats; 0 or > NUM_BEATS means NUM_BEATS.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  IDX_W  table entry to write; writes with `wr_addr ≥ NUM_BEATS` are ignored.
- `wr_data`  in  CH*DIV_W  dividers; channel k occupies bits [k*DIV_W +: DIV_W], with channel 0 = right and channel 1 = left.
- `note_div`  out  CH*DIV_W  current dividers, same packing; all zero when not sounding.
- `beat_idx`  out  IDX_W  current beat.
- `beat_ones`  out  4  BCD ones digit of `beat_idx`.
- `beat_tens`  out  4  BCD tens digit of `beat_idx`.
- `playing`  out  1  high in PLAY and PAUSE.
- `done`  out  1  one-cycle pulse when a non-looping sequence ends.

## Operation
- Table: NUM_BEATS × CH×DIV_W registers. All entries are cleared to 0 by `rst`. A write takes effect on the clock edge where `wr_en` is high, in any state.
- States:
  - IDLE: reset state.
  - PLAY: `start` → PLAY from any state. The beat index, BCD digits and tick counter are set to 0, and `seq_len` is latched into `len_q`.
  - PAUSE: PLAY with `pause` high → PAUSE. PAUSE with `pause` low → PLAY.
  - `stop` → IDLE from any state.
- Priority per cycle: `stop` > `start` > `pause`. `start` in PLAY or PAUSE restarts at beat 0.
- Tick counter counts 0..TICK_DIV-1 in PLAY only; it freezes in PAUSE. At terminal count it returns to 0 and the beat advances.
- Beat advance when `beat_idx == len_q-1`:
  - If `loop_en` is high, wrap to 0.
  - Otherwise go to IDLE, pulse `done` for one cycle, and hold `beat_idx` at 0.
- Beat advance otherwise: `beat_idx` += 1.
- BCD digits track `beat_idx` as a parallel counter. Ones wrap 9→0 with a tens carry. Both digits clear on wrap, start and stop. No divider is used.
- `note_div` is registered. It equals `table[beat_idx]` in PLAY and all zero in IDLE and PAUSE.
- `loop_en` is sampled only at the end of the last beat, so it may change mid-sequence.

## Timing
- Reset values: `note_div` = 0, `beat_idx` = 0, `beat_ones` = 0, `beat_tens` = 0, `playing` = 0, `done` = 0. Tick counter = 0, `len_q` = NUM_BEATS, state IDLE.
- `start` at edge t: from t+1, state is PLAY, `beat_idx` = 0, `note_div` = `table[0]`, `playing` = 1.
- Beat duration: exactly TICK_DIV cycles. `beat_idx` and `note_div` change on the same edge.
- Last beat of a non-looping sequence, edge e: `done` = 1, `playing` = 0, `note_div` = 0 during cycle e+1; `done` = 0 at e+2.
- `pause` rising edge: at the next edge, `note_div` = 0 and the tick count is held. `pause` falling edge: the next edge resumes with the remaining ticks of the same beat.
- Table write to the current beat at edge w: `note_div` shows the new value from edge w+1. Write-read collision is resolved as read-old for cycle w and new thereafter.
- `rst` asserted mid-play: all outputs take their reset values immediately (asynchronous), and the table clears.
- `seq_len` = 1 with `loop_en` high: `beat_idx` stays 0 and `note_div` is continuously `table[0]`.

## Test plan
- Bench parameters: `TICK_DIV=4`, `NUM_BEATS=12`, `CH=2`, `DIV_W=22`. Load `table[i]` = {left = 1000+i, right = 2000+i}.
- Basic play: `seq_len=3`, `start` → `note_div` right channel = 2000, 2001, 2002, each held 4 cycles; `done` pulses once; then `note_div` = 0 and `playing` = 0.
- Loop and BCD: `seq_len=0`, `loop_en=1` → `beat_idx` runs 0..11 then 0. At beat 10, `beat_tens`=1 and `beat_ones`=0. `done` never pulses.
- Pause mid-beat: assert `pause` after 2 ticks of beat 1 for 7 cycles → `note_div`=0 and `beat_idx`=1 throughout; after release, beat 1 lasts exactly 2 more cycles.
- Collisions:
  - `start` and `stop` in the same cycle → IDLE.
  - `start` during beat 5 → `beat_idx`=0 on the next cycle.
  - Writing `table[2]` = {7, 9} while on beat 2 → `note_div` = {7, 9} on the following cycle.
- Reset: assert `rst` asynchronously during beat 4 → all outputs 0 within the same cycle. After release, `start` gives `note_div` = 0, because the table was cleared.

Source files
------------

// File: rtl/melody_sequencer.sv
// Tempo-driven note sequencer: plays a loadable per-channel divider table at a fixed tick rate.
// Latency: start/stop/pause act on the next edge; note_div, beat_idx and BCD digits are registered.
// Backpressure: none; control is pulse/level driven and the table accepts a write every cycle.
module melody_sequencer #(
    parameter int CH        = 2,
    parameter int DIV_W     = 22,
    parameter int NUM_BEATS = 32,
    parameter int TICK_DIV  = 25_000_000,
    parameter int IDX_W     = $clog2(NUM_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  loop_en,
    input  logic [IDX_W:0]        seq_len,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [CH*DIV_W-1:0]   wr_data,
    output logic [CH*DIV_W-1:0]   note_div,
    output logic [IDX_W-1:0]      beat_idx,
    output logic [3:0]            beat_ones,
    output logic [3:0]            beat_tens,
    output logic                  playing,
    output logic                  done
);

    localparam int W     = CH * DIV_W;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W:0]   LEN_MAX   = (IDX_W + 1)'(NUM_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [IDX_W-1:0]   beat_q, beat_d;
    logic [3:0]         ones_q, ones_d;
    logic [3:0]         tens_q, tens_d;
    logic [IDX_W:0]     len_q, len_d;
    logic               done_q, done_d;
    logic [W-1:0]       note_q, note_d;
    logic [W-1:0]       table_q [NUM_BEATS];
    logic [IDX_W:0]     start_len;
    logic               last_beat;

    // Zero or oversize length means "play the whole table".
    assign start_len = (seq_len == '0 || seq_len > LEN_MAX) ? LEN_MAX : seq_len;
    assign last_beat = ({1'b0, beat_q} == (len_q - (IDX_W + 1)'(1)));

    // Next-state: stop beats start beats pause; BCD digits count alongside the beat index.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        beat_d  = beat_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        len_d   = len_q;
        done_d  = 1'b0;
        note_d  = '0;
        if (stop) begin
            state_d = S_IDLE;
            tick_d  = '0;
            beat_d  = '0;
            ones_d  = '0;
            tens_d  = '0;
        end else if (start) begin
            state_d = S_PLAY;
            tick_d  = '0;
            beat_d  = '0;
            ones_d  = '0;
            tens_d  = '0;
            len_d   = start_len;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (pause) begin
                        // Tick count is frozen from this edge on.
                        state_d = S_PAUSE;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (last_beat) begin
                            beat_d = '0;
                            ones_d = '0;
                            tens_d = '0;
                            if (!loop_en) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + IDX_W'(1);
                            if (ones_q == 4'd9) begin
                                ones_d = 4'd0;
                                tens_d = tens_q + 4'd1;
                            end else begin
                                ones_d = ones_q + 4'd1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    // Resume keeps the held tick count, finishing the same beat.
                    if (!pause) begin
                        state_d = S_PLAY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Read of the table is pre-write, so a write to the current beat shows one edge later.
        if (state_d == S_PLAY) begin
            note_d = table_q[beat_d];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            beat_q  <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            len_q   <= LEN_MAX;
            done_q  <= 1'b0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            len_q   <= len_d;
            done_q  <= done_d;
            note_q  <= note_d;
        end
    end

    // Divider table; writable in any state, out-of-range addresses dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LEN_MAX)) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign note_div  = note_q;
    assign beat_idx  = beat_q;
    assign beat_ones = ones_q;
    assign beat_tens = tens_q;
    assign playing   = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: table-driven play vectors plus hand-built corner sequences.
// Latency: every step drives inputs, then checks outputs #1 after the following rising edge.
// Backpressure: not applicable; the bench owns all control inputs.
module tb_melody_sequencer;

    localparam int CH        = 2;
    localparam int DIV_W     = 22;
    localparam int NUM_BEATS = 12;
    localparam int TICK_DIV  = 4;
    localparam int IDX_W     = $clog2(NUM_BEATS);
    localparam int W         = CH * DIV_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop, pause, loop_en;
    logic [IDX_W:0]   seq_len;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     note_div;
    logic [IDX_W-1:0] beat_idx;
    logic [3:0]       beat_ones, beat_tens;
    logic             playing, done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic             start, stop, pause, loop_en;
        logic [IDX_W:0]   seq_len;
        logic             wr_en;
        logic [IDX_W-1:0] wr_addr;
        logic [W-1:0]     wr_data;
        logic [W-1:0]     e_note;
        logic [IDX_W-1:0] e_beat;
        logic             e_play, e_done;
    } vec_t;

    vec_t exp_q [$];
    vec_t basic [15];

    melody_sequencer #(
        .CH(CH), .DIV_W(DIV_W), .NUM_BEATS(NUM_BEATS), .TICK_DIV(TICK_DIV), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
        .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note_div(note_div), .beat_idx(beat_idx), .beat_ones(beat_ones), .beat_tens(beat_tens),
        .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] nd(int l, int r);
        return {l[DIV_W-1:0], r[DIV_W-1:0]};
    endfunction

    function automatic vec_t mk(logic st, logic sp, logic pa, logic lp, int len,
                                logic [W-1:0] note, int beat, logic play, logic dn);
        vec_t v;
        v.start   = st;
        v.stop    = sp;
        v.pause   = pa;
        v.loop_en = lp;
        v.seq_len = len[IDX_W:0];
        v.wr_en   = 1'b0;
        v.wr_addr = '0;
        v.wr_data = '0;
        v.e_note  = note;
        v.e_beat  = beat[IDX_W-1:0];
        v.e_play  = play;
        v.e_done  = dn;
        return v;
    endfunction

    // Looping playback from a start at step 0: beat index for step k.
    function automatic int lbeat(int k, int len);
        return (k / TICK_DIV) % len;
    endfunction

    function automatic logic [W-1:0] tnote(int b);
        return nd(1000 + b, 2000 + b);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(vec_t v);
        vec_t e;
        int   b;
        start   = v.start;
        stop    = v.stop;
        pause   = v.pause;
        loop_en = v.loop_en;
        seq_len = v.seq_len;
        wr_en   = v.wr_en;
        wr_addr = v.wr_addr;
        wr_data = v.wr_data;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        b = int'(e.e_beat);
        chk("note_div", 64'(note_div), 64'(e.e_note));
        chk("beat_idx", 64'(beat_idx), 64'(e.e_beat));
        chk("beat_ones", 64'(beat_ones), 64'(b % 10));
        chk("beat_tens", 64'(beat_tens), 64'(b / 10));
        chk("playing", 64'(playing), 64'(e.e_play));
        chk("done", 64'(done), 64'(e.e_done));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_note"}, 64'(note_div), 64'd0);
        chk({tag, "_beat"}, 64'(beat_idx), 64'd0);
        chk({tag, "_ones"}, 64'(beat_ones), 64'd0);
        chk({tag, "_tens"}, 64'(beat_tens), 64'd0);
        chk({tag, "_playing"}, 64'(playing), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   b;

        // Basic play, seq_len=3: three beats of four cycles, then done pulse.
        for (int i = 0; i < 12; i++) begin
            b = i / TICK_DIV;
            basic[i] = mk(i == 0, 1'b0, 1'b0, 1'b0, 3, tnote(b), b, 1'b1, 1'b0);
        end
        basic[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 3, '0, 0, 1'b0, 1'b1);
        basic[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 3, '0, 0, 1'b0, 1'b0);
        basic[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 3, '0, 0, 1'b0, 1'b0);

        rst = 1'b1;
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        seq_len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load table while idle.
        for (int i = 0; i < NUM_BEATS; i++) begin
            v = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 1'b0);
            v.wr_en   = 1'b1;
            v.wr_addr = i[IDX_W-1:0];
            v.wr_data = tnote(i);
            step(v);
        end

        for (int i = 0; i < 15; i++) step(basic[i]);

        // Full-length loop: 0..11 then wrap; BCD tens digit exercised at beats 10, 11.
        for (int k = 0; k < 13 * TICK_DIV; k++) begin
            b = lbeat(k, NUM_BEATS);
            step(mk(k == 0, 1'b0, 1'b0, 1'b1, 0, tnote(b), b, 1'b1, 1'b0));
        end
        step(mk(1'b0, 1'b1, 1'b0, 1'b1, 0, '0, 0, 1'b0, 1'b0));

        // Pause after two ticks of beat 1, held for 7 cycles.
        for (int k = 0; k < 7; k++) begin
            b = k / TICK_DIV;
            step(mk(k == 0, 1'b0, 1'b0, 1'b0, 0, tnote(b), b, 1'b1, 1'b0));
        end
        for (int k = 0; k < 7; k++) step(mk(1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 1, 1'b1, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, tnote(1), 1, 1'b1, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, tnote(1), 1, 1'b1, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, tnote(2), 2, 1'b1, 1'b0));

        // start and stop together: stop wins.
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 0, 1'b0, 1'b0));
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 0, 1'b0, 1'b0));

        // seq_len=1 looping: stays on beat 0 indefinitely.
        for (int k = 0; k < 10; k++) step(mk(k == 0, 1'b0, 1'b0, 1'b1, 1, tnote(0), 0, 1'b1, 1'b0));

        // Restart from PLAY mid beat 5.
        for (int k = 0; k < 22; k++) begin
            b = lbeat(k, NUM_BEATS);
            step(mk(k == 0, 1'b0, 1'b0, 1'b1, 0, tnote(b), b, 1'b1, 1'b0));
        end
        step(mk(1'b1, 1'b0, 1'b0, 1'b1, 0, tnote(0), 0, 1'b1, 1'b0));

        // Write table[2] = {left 7, right 9} while on beat 2: old value for one more cycle.
        for (int k = 1; k < 18; k++) begin
            b = lbeat(k, NUM_BEATS);
            v = mk(1'b0, 1'b0, 1'b0, 1'b1, 0, tnote(b), b, 1'b1, 1'b0);
            if (k == 9) begin
                v.wr_en   = 1'b1;
                v.wr_addr = 2;
                v.wr_data = nd(7, 9);
            end
            if (k == 10 || k == 11) v.e_note = nd(7, 9);
            step(v);
        end

        // Asynchronous reset during beat 4: outputs clear before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table was cleared by reset: playback is silent.
        for (int k = 0; k < 6; k++) begin
            b = k / TICK_DIV;
            step(mk(k == 0, 1'b0, 1'b0, 1'b0, 0, '0, b, 1'b1, 1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
